// File: rtl/tpu_pkg.sv
// Shared constants and types for the matrix-unit result drain path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tpu_pkg;

    localparam int N     = 3;
    localparam int IN_W  = 24;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] out_t;

endpackage

// File: rtl/requant_lane.sv
// Requantizes one accumulator element: rounding arithmetic shift, optional ReLU, saturation.
// Latency: purely combinational.
// Backpressure: none; the caller holds the inputs stable while the result is consumed.
module requant_lane #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       shift,
    input  logic             relu,
    output logic [OUT_W-1:0] q
);

    // One extra bit so the half-LSB rounding add cannot wrap at the positive limit.
    localparam int W = ACC_W + 1;
    localparam logic signed [W-1:0] QMAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] QMIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] t;

    // Round half toward +inf, shift, clamp negatives under ReLU, then saturate to OUT_W.
    always_comb begin
        ext = {acc[ACC_W-1], acc};
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = W'(1) << (shift - 5'd1);
        end
        sum = ext + rnd;
        t   = sum >>> shift;
        if (relu && t[W-1]) begin
            t = '0;
        end
        if (t > QMAX) begin
            q = QMAX[OUT_W-1:0];
        end else if (t < QMIN) begin
            q = QMIN[OUT_W-1:0];
        end else begin
            q = t[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/tpu_result_drain.sv
// Accumulates K-tiles of systolic results, then streams requantized rows to writeback.
// Latency: last-tile accept in cycle T gives row 0 in T+1; rows back-to-back thereafter.
// Backpressure: res_ready low while draining; rows hold stable while out_ready is low.
module tpu_result_drain #(
    parameter int N     = tpu_pkg::N,
    parameter int IN_W  = tpu_pkg::IN_W,
    parameter int ACC_W = tpu_pkg::ACC_W,
    parameter int OUT_W = tpu_pkg::OUT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             res_valid,
    output logic                             res_ready,
    input  logic                             res_last,
    input  logic [N-1:0][N-1:0][IN_W-1:0]    res_data,
    input  logic [4:0]                       cfg_shift,
    input  logic                             cfg_relu,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N-1:0][OUT_W-1:0]          out_data,
    output logic [$clog2(N)-1:0]             out_row,
    output logic                             out_last,
    output logic                             acc_ovf
);

    localparam int RW = $clog2(N);

    tpu_pkg::drain_state_t state_q, state_d;

    logic [N-1:0][N-1:0][ACC_W-1:0] acc_q;
    logic [N-1:0][N-1:0][ACC_W-1:0] acc_nxt;
    logic [N*N-1:0]                 sat_vec;
    logic [RW-1:0]                  row_q;
    logic [4:0]                     shift_q;
    logic                           relu_q;
    logic                           accept;
    logic                           beat;
    logic                           last_beat;

    assign accept    = res_valid && res_ready;
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && out_last;
    assign out_row   = row_q;

    // Saturating add per element; in IDLE the base is zero so the first tile is a plain load.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [ACC_W-1:0] base;
            logic [ACC_W:0]   sum;
            assign base = (state_q == tpu_pkg::IDLE) ? '0 : acc_q[r][c];
            assign sum  = {base[ACC_W-1], base}
                        + {{(ACC_W+1-IN_W){res_data[r][c][IN_W-1]}}, res_data[r][c]};
            assign sat_vec[r*N+c] = sum[ACC_W] ^ sum[ACC_W-1];
            assign acc_nxt[r][c]  = !sat_vec[r*N+c] ? sum[ACC_W-1:0]
                                  : (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                : {1'b0, {(ACC_W-1){1'b1}}});
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= tpu_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, all derived from registered state.
    always_comb begin
        state_d   = state_q;
        res_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            tpu_pkg::IDLE, tpu_pkg::ACCUM: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    state_d = res_last ? tpu_pkg::DRAIN : tpu_pkg::ACCUM;
                end
            end
            tpu_pkg::DRAIN: begin
                out_valid = 1'b1;
                out_last  = (row_q == RW'(N-1));
                if (out_ready && (row_q == RW'(N-1))) begin
                    state_d = tpu_pkg::IDLE;
                end
            end
            default: begin
                state_d = tpu_pkg::IDLE;
            end
        endcase
    end

    // Buffer, latched config, sticky overflow and row counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            row_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_ovf <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= acc_nxt;
                if (state_q == tpu_pkg::IDLE) begin
                    shift_q <= cfg_shift;
                    relu_q  <= cfg_relu;
                    acc_ovf <= |sat_vec;
                end else begin
                    acc_ovf <= acc_ovf | (|sat_vec);
                end
            end
            if (last_beat) begin
                row_q <= '0;
                acc_q <= '0;
            end else if (beat) begin
                row_q <= row_q + RW'(1);
            end
        end
    end

    // One requantizer per column, fed from the row currently on the output.
    for (genvar c = 0; c < N; c++) begin : g_lane
        requant_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .acc   (acc_q[row_q][c]),
            .shift (shift_q),
            .relu  (relu_q),
            .q     (out_data[c])
        );
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Self-checking bench for tpu_result_drain against an arithmetic reference model.
// Latency: checks first-row timing and back-to-back drain cycles.
// Backpressure: exercises held out_ready and blocked res_valid during drain.
module tb_tpu_result_drain;

    localparam int N     = 3;
    localparam int IN_W  = 24;
    localparam int OUT_W = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          res_valid;
    logic                          res_ready;
    logic                          res_last;
    logic [N-1:0][N-1:0][IN_W-1:0] res_data;
    logic [4:0]                    cfg_shift;
    logic                          cfg_relu;
    logic                          out_valid;
    logic                          out_ready;
    logic [N-1:0][OUT_W-1:0]       out_data;
    logic [1:0]                    out_row;
    logic                          out_last;
    logic                          acc_ovf;

    int checks = 0;
    int errors = 0;

    int     tile   [N][N];
    longint acc_m  [N][N];
    int     sh_m;
    bit     relu_m;
    bit     ovf_m;
    int     got     [N][N];
    int     got_row [N];
    bit     got_last[N];
    int     got_cyc [N];
    bit     got_stable;
    bit     got_ok;

    tpu_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_last  (res_last),
        .res_data  (res_data),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .acc_ovf   (acc_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int rand_elem();
        int v = int'($urandom);
        return (v <<< 8) >>> 8;
    endfunction

    function automatic longint clamp_acc(longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // floor((a + half) / 2^s), then ReLU, then clamp to int8
    function automatic int rq(longint a, int s, bit r);
        longint t = a;
        if (s > 0) t = t + (longint'(1) << (s - 1));
        t = t >>> s;
        if (r && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return int'(t);
    endfunction

    function automatic void model_tile(bit first);
        if (first) begin
            ovf_m  = 1'b0;
            sh_m   = int'(cfg_shift);
            relu_m = cfg_relu;
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                longint s = (first ? 64'sd0 : acc_m[r][c]) + longint'(tile[r][c]);
                longint k = clamp_acc(s);
                if (k != s) ovf_m = 1'b1;
                acc_m[r][c] = k;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic put_tile(input bit last, output bit ok);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                res_data[r][c] = IN_W'(tile[r][c]);
        res_last  = last;
        res_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (res_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        res_last  = 1'b0;
    endtask

    task automatic drain_rows(input int pct);
        int  k = 0;
        bit  prev_stall = 1'b0;
        logic [N-1:0][OUT_W-1:0] pd;
        logic [1:0] pr;
        logic pl;
        got_stable = 1'b1;
        pd = '0; pr = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 300 && k < N; cyc++) begin
            out_ready = ($urandom_range(99) < pct);
            if (prev_stall && (out_valid !== 1'b1 || out_data !== pd || out_row !== pr || out_last !== pl))
                got_stable = 1'b0;
            prev_stall = out_valid && !out_ready;
            pd = out_data; pr = out_row; pl = out_last;
            if (out_valid && out_ready) begin
                got_row[k]  = int'(out_row);
                got_last[k] = out_last;
                got_cyc[k]  = cyc;
                for (int c = 0; c < N; c++) got[k][c] = int'($signed(out_data[c]));
                k++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        got_ok = (k == N);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got %b want 1", res_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_row !== 2'd0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_row_last got %0d/%b want 0/0", out_row, out_last); end
        checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL reset_acc_ovf got %b want 0", acc_ovf); end
    endtask

    task automatic test_single_tile();
        bit ok;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tile[r][c] = rand_elem();
        tile[0][0] = 291;
        cfg_shift = 5'd4; cfg_relu = 1'b0;
        model_tile(1'b1);
        put_tile(1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept got timeout want accept"); end
        checks++; if (out_valid !== 1'b1 || out_row !== 2'd0) begin errors++; $display("FAIL single_latency got valid=%b row=%0d want 1/0", out_valid, out_row); end
        drain_rows(100);
        checks++; if (!got_ok) begin errors++; $display("FAIL single_drain got timeout want 3 beats"); end
        checks++; if (got[0][0] !== 18) begin errors++; $display("FAIL single_elem00 got %0d want 18", got[0][0]); end
        for (int k = 0; k < N; k++) begin
            checks++; if (got_row[k] !== k || got_last[k] !== (k == N-1) || got_cyc[k] !== k) begin
                errors++; $display("FAIL single_seq beat %0d got row=%0d last=%b cyc=%0d want %0d/%b/%0d", k, got_row[k], got_last[k], got_cyc[k], k, (k == N-1), k);
            end
            for (int c = 0; c < N; c++) begin
                checks++; if (got[k][c] !== rq(acc_m[k][c], sh_m, relu_m)) begin
                    errors++; $display("FAIL single_data [%0d][%0d] got %0d want %0d", k, c, got[k][c], rq(acc_m[k][c], sh_m, relu_m));
                end
            end
        end
        checks++; if (res_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_return got ready=%b valid=%b want 1/0", res_ready, out_valid); end
    endtask

    task automatic test_round_relu_sat();
        bit ok;
        int want;
        for (int pass = 0; pass < 3; pass++) begin
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++)
                tile[r][c] = (pass == 2) ? (((r + c) % 2 == 0) ? 5000 : -5000) : -40;
            cfg_shift = (pass == 2) ? 5'd0 : 5'd3;
            cfg_relu  = (pass == 1);
            model_tile(1'b1);
            put_tile(1'b1, ok);
            drain_rows(100);
            checks++; if (!ok || !got_ok) begin errors++; $display("FAIL rrs_handshake pass %0d got ok=%b/%b want 1/1", pass, ok, got_ok); end
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
                want = (pass == 0) ? -5 : (pass == 1) ? 0 : (((r + c) % 2 == 0) ? 127 : -128);
                checks++; if (got[r][c] !== want) begin errors++; $display("FAIL rrs_data pass %0d [%0d][%0d] got %0d want %0d", pass, r, c, got[r][c], want); end
            end
        end
    endtask

    task automatic test_two_tiles();
        bit ok;
        cfg_shift = 5'd0; cfg_relu = 1'b0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tile[r][c] = 100;
        model_tile(1'b1);
        put_tile(1'b0, ok);
        checks++; if (!ok || res_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL two_first got ok=%b ready=%b valid=%b want 1/1/0", ok, res_ready, out_valid); end
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tile[r][c] = 27;
        model_tile(1'b0);
        put_tile(1'b1, ok);
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) res_data[r][c] = 24'd1;
        res_valid = 1'b1; res_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (res_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== 2'd0) begin
                errors++; $display("FAIL two_block cycle %0d got ready=%b valid=%b row=%0d want 0/1/0", i, res_ready, out_valid, out_row);
            end
            @(posedge clk); #1;
        end
        res_valid = 1'b0; res_last = 1'b0;
        drain_rows(100);
        checks++; if (!got_ok) begin errors++; $display("FAIL two_drain got timeout want 3 beats"); end
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
            checks++; if (got[r][c] !== 127) begin errors++; $display("FAIL two_data [%0d][%0d] got %0d want 127", r, c, got[r][c]); end
        end
        checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL two_ovf got %b want 0", acc_ovf); end
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tile[r][c] = rand_elem();
        cfg_shift = 5'($urandom_range(1, 12)); cfg_relu = 1'($urandom_range(1));
        model_tile(1'b1);
        put_tile(1'b1, ok);
        out_ready = 1'b1;
        checks++; if (!ok || out_row !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_start got ok=%b row=%0d valid=%b want 1/0/1", ok, out_row, out_valid); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        cfg_shift = ~cfg_shift; cfg_relu = ~cfg_relu;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            checks++; if (out_row !== 2'd1 || out_valid !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got row=%0d valid=%b want 1/1", i, out_row, out_valid); end
            for (int c = 0; c < N; c++) begin
                checks++; if (int'($signed(out_data[c])) !== rq(acc_m[1][c], sh_m, relu_m)) begin
                    errors++; $display("FAIL bp_data cycle %0d col %0d got %0d want %0d", i, c, $signed(out_data[c]), rq(acc_m[1][c], sh_m, relu_m));
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (out_row !== 2'd2 || out_last !== 1'b1) begin errors++; $display("FAIL bp_advance got row=%0d last=%b want 2/1", out_row, out_last); end
        for (int c = 0; c < N; c++) begin
            checks++; if (int'($signed(out_data[c])) !== rq(acc_m[2][c], sh_m, relu_m)) begin
                errors++; $display("FAIL bp_row2 col %0d got %0d want %0d", c, $signed(out_data[c]), rq(acc_m[2][c], sh_m, relu_m));
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL bp_end got valid=%b ready=%b want 0/1", out_valid, res_ready); end
    endtask

    task automatic test_overflow_and_reset();
        bit ok;
        bit all_ok = 1'b1;
        cfg_shift = 5'd24; cfg_relu = 1'b0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tile[r][c] = (r == 0) ? 8388607 : rand_elem();
        for (int t = 0; t < 258; t++) begin
            model_tile(t == 0);
            put_tile(t == 257, ok);
            all_ok &= ok;
            if (t == 0) begin
                checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first got %b want 0", acc_ovf); end
            end
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL ovf_accept got timeout want all accepted"); end
        checks++; if (acc_ovf !== ovf_m || acc_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", acc_ovf); end
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            checks++; if (int'($signed(out_data[c])) !== rq(acc_m[0][c], sh_m, relu_m)) begin
                errors++; $display("FAIL ovf_row0 col %0d got %0d want %0d", c, $signed(out_data[c]), rq(acc_m[0][c], sh_m, relu_m));
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || res_ready !== 1'b1 || acc_ovf !== 1'b0) begin
            errors++; $display("FAIL rst_mid got valid=%b ready=%b ovf=%b want 0/1/0", out_valid, res_ready, acc_ovf);
        end
        checks++; if (out_row !== 2'd0 || out_data !== '0) begin errors++; $display("FAIL rst_mid_data got row=%0d data=%h want 0/0", out_row, out_data); end
    endtask

    task automatic test_random();
        bit ok;
        int ntiles;
        for (int m = 0; m < 15; m++) begin
            ntiles    = $urandom_range(1, 4);
            cfg_shift = ($urandom_range(1) == 1) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31));
            cfg_relu  = 1'($urandom_range(1));
            for (int t = 0; t < ntiles; t++) begin
                if (t > 0) begin cfg_shift = 5'($urandom); cfg_relu = 1'($urandom); end
                for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tile[r][c] = rand_elem();
                model_tile(t == 0);
                put_tile(t == ntiles - 1, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_accept mat %0d tile %0d got timeout want accept", m, t); end
            end
            checks++; if (acc_ovf !== ovf_m) begin errors++; $display("FAIL rnd_ovf mat %0d got %b want %b", m, acc_ovf, ovf_m); end
            drain_rows(60);
            checks++; if (!got_ok || !got_stable) begin errors++; $display("FAIL rnd_drain mat %0d got ok=%b stable=%b want 1/1", m, got_ok, got_stable); end
            for (int k = 0; k < N; k++) begin
                checks++; if (got_row[k] !== k || got_last[k] !== (k == N-1)) begin
                    errors++; $display("FAIL rnd_seq mat %0d beat %0d got row=%0d last=%b", m, k, got_row[k], got_last[k]);
                end
                for (int c = 0; c < N; c++) begin
                    checks++; if (got[k][c] !== rq(acc_m[k][c], sh_m, relu_m)) begin
                        errors++; $display("FAIL rnd_data mat %0d [%0d][%0d] got %0d want %0d", m, k, c, got[k][c], rq(acc_m[k][c], sh_m, relu_m));
                    end
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        res_valid = 1'b0;
        res_last  = 1'b0;
        res_data  = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_tile();
        test_round_relu_sat();
        test_two_tiles();
        test_backpressure();
        test_overflow_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
